// File: rtl/conditional_demux1.sv
// ============================================================================
// Module   : conditional_demux1
// Purpose  : Versat unit steering one data stream to out0/out1 by in0[0],
//            counting out0 samples, with run/done sequencing and start delay.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module conditional_demux1 #(
   parameter int DELAY_W  = 32,
   parameter int AMOUNT_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                running,
   input  logic                run,
   output logic                done,
   input  logic [DELAY_W-1:0]  delay0,
   input  logic [AMOUNT_W-1:0] amount,
   input  logic [31:0]         in0,
   input  logic [31:0]         in1,
   output logic [31:0]         out0,
   output logic [31:0]         out1,
   output logic [31:0]         out2
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   state_t              state, state_n;
   logic [DELAY_W-1:0]  dcnt, dcnt_n;
   logic [AMOUNT_W-1:0] rcnt, rcnt_n;
   logic [31:0]         out0_n, out1_n, out2_n;
   logic                done_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         dcnt  <= '0;
         rcnt  <= '0;
         out0  <= '0;
         out1  <= '0;
         out2  <= '0;
         done  <= 1'b1;
      end else begin
         state <= state_n;
         dcnt  <= dcnt_n;
         rcnt  <= rcnt_n;
         out0  <= out0_n;
         out1  <= out1_n;
         out2  <= out2_n;
         done  <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      dcnt_n  = dcnt;
      rcnt_n  = rcnt;
      out0_n  = out0;
      out1_n  = out1;
      out2_n  = out2;
      done_n  = done;

      // A run pulse restarts unconditionally and discards this cycle's sample.
      if (run) begin
         dcnt_n = delay0;
         rcnt_n = amount;
         out2_n = '0;
         if (amount == '0) begin
            done_n  = 1'b1;
            state_n = IDLE;
         end else begin
            done_n  = 1'b0;
            state_n = (delay0 != '0) ? DELAY : ACTIVE;
         end
      end else if (running) begin
         case (state)
            DELAY: begin
               dcnt_n = dcnt - 1'b1;
               if (dcnt == DELAY_W'(1))
                  state_n = ACTIVE;
            end
            ACTIVE: begin
               if (in0[0]) begin
                  out0_n = in1;
                  out2_n = out2 + 32'd1;
               end else begin
                  out1_n = in1;
               end
               rcnt_n = rcnt - 1'b1;
               if (rcnt == AMOUNT_W'(1)) begin
                  done_n  = 1'b1;
                  state_n = IDLE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_conditional_demux1.sv
// Directed bench for conditional_demux1; observed outputs are packed as
// {done,out2,out1,out0} and compared against hand-computed vectors.
`default_nettype none
`timescale 1ns/1ps

module tb_conditional_demux1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        running = 1'b0;
   logic        run = 1'b0;
   logic        done;
   logic [31:0] delay0 = '0;
   logic [31:0] amount = '0;
   logic [31:0] in0 = '0;
   logic [31:0] in1 = '0;
   logic [31:0] out0, out1, out2;

   int cmp_cnt = 0;
   int mis_cnt = 0;

   localparam logic [31:0] DA = 32'hAAAA0001, DB = 32'hBBBB0002, DC = 32'hCCCC0003;
   localparam logic [31:0] DD = 32'hDDDD0004, DE = 32'hEEEE0005, DF = 32'hFFFF0006;
   localparam logic [31:0] DG = 32'h12340007, DH = 32'h56780008, DI = 32'h9ABC0009;
   localparam logic [31:0] DJ = 32'h0000000A, DK = 32'h0000000B, DL = 32'h0000000C;
   localparam logic [31:0] DM = 32'h0000000D, DN = 32'h0000000E, DP = 32'h0000000F;
   localparam logic [31:0] JUNK = 32'hDEADBEEF;

   conditional_demux1 #(.DELAY_W(32), .AMOUNT_W(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .running (running),
      .run     (run),
      .done    (done),
      .delay0  (delay0),
      .amount  (amount),
      .in0     (in0),
      .in1     (in1),
      .out0    (out0),
      .out1    (out1),
      .out2    (out2)
   );

   always #5 clk = ~clk;

   logic [96:0] obs;
   assign obs = {done, out2, out1, out0};

   // Apply one cycle of inputs on the falling edge, then settle past the rising edge.
   task automatic tick(input logic r, input logic rn, input logic go,
                       input logic [31:0] sel, input logic [31:0] dat);
      @(negedge clk);
      rst = r; running = rn; run = go; in0 = sel; in1 = dat;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [96:0] exp_v;
      tick(1'b1, 1'b1, 1'b0, 32'h1, JUNK);
      tick(1'b1, 1'b1, 1'b0, 32'h0, JUNK);
      exp_v = {1'b1, 32'd0, 32'd0, 32'd0};
      cmp_cnt++;
      if (obs !== exp_v) begin mis_cnt++; $display("FAIL reset_state: got %h expected %h", obs, exp_v); end
      tick(1'b0, 1'b1, 1'b0, 32'h1, DA);
      tick(1'b0, 1'b1, 1'b0, 32'h0, DB);
      tick(1'b0, 1'b1, 1'b0, 32'h1, DC);
      cmp_cnt++;
      if (obs !== exp_v) begin mis_cnt++; $display("FAIL reset_idle_ignores: got %h expected %h", obs, exp_v); end
   endtask

   task automatic test_basic;
      logic [96:0] exp_v;
      delay0 = 32'd0; amount = 32'd4;
      tick(1'b0, 1'b1, 1'b1, 32'h1, JUNK);
      exp_v = {1'b0, 32'd0, 32'd0, 32'd0};
      cmp_cnt++;
      if (obs !== exp_v) begin mis_cnt++; $display("FAIL basic_after_run: got %h expected %h", obs, exp_v); end
      tick(1'b0, 1'b1, 1'b0, 32'h1, DA);
      exp_v = {1'b0, 32'd1, 32'd0, DA};
      cmp_cnt++;
      if (obs !== exp_v) begin mis_cnt++; $display("FAIL basic_s1: got %h expected %h", obs, exp_v); end
      tick(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, DB);
      exp_v = {1'b0, 32'd1, DB, DA};
      cmp_cnt++;
      if (obs !== exp_v) begin mis_cnt++; $display("FAIL basic_s2_bit0_only: got %h expected %h", obs, exp_v); end
      tick(1'b0, 1'b1, 1'b0, 32'h1, DC);
      exp_v = {1'b0, 32'd2, DB, DC};
      cmp_cnt++;
      if (obs !== exp_v) begin mis_cnt++; $display("FAIL basic_s3: got %h expected %h", obs, exp_v); end
      tick(1'b0, 1'b1, 1'b0, 32'h3, DD);
      exp_v = {1'b1, 32'd3, DB, DD};
      cmp_cnt++;
      if (obs !== exp_v) begin mis_cnt++; $display("FAIL basic_s4_done: got %h expected %h", obs, exp_v); end
      tick(1'b0, 1'b1, 1'b0, 32'h0, JUNK);
      cmp_cnt++;
      if (obs !== exp_v) begin mis_cnt++; $display("FAIL basic_idle_hold: got %h expected %h", obs, exp_v); end
   endtask

   task automatic test_delay;
      logic [96:0] exp_v;
      delay0 = 32'd3; amount = 32'd2;
      tick(1'b0, 1'b1, 1'b1, 32'h1, JUNK);
      exp_v = {1'b0, 32'd0, DB, DD};
      for (int k = 0; k < 3; k++) begin
         tick(1'b0, 1'b1, 1'b0, 32'h1, JUNK);
         cmp_cnt++;
         if (obs !== exp_v) begin mis_cnt++; $display("FAIL delay_wait%0d: got %h expected %h", k, obs, exp_v); end
      end
      tick(1'b0, 1'b1, 1'b0, 32'h1, DE);
      exp_v = {1'b0, 32'd1, DB, DE};
      cmp_cnt++;
      if (obs !== exp_v) begin mis_cnt++; $display("FAIL delay_s1: got %h expected %h", obs, exp_v); end
      tick(1'b0, 1'b1, 1'b0, 32'h0, DF);
      exp_v = {1'b1, 32'd1, DF, DE};
      cmp_cnt++;
      if (obs !== exp_v) begin mis_cnt++; $display("FAIL delay_s2_done: got %h expected %h", obs, exp_v); end
   endtask

   task automatic test_stall;
      logic [96:0] exp_v;
      delay0 = 32'd0; amount = 32'd3;
      tick(1'b0, 1'b1, 1'b1, 32'h0, JUNK);
      tick(1'b0, 1'b1, 1'b0, 32'h1, DG);
      exp_v = {1'b0, 32'd1, DF, DG};
      cmp_cnt++;
      if (obs !== exp_v) begin mis_cnt++; $display("FAIL stall_s1: got %h expected %h", obs, exp_v); end
      for (int k = 0; k < 5; k++) begin
         tick(1'b0, 1'b0, 1'b0, 32'h0, JUNK);
         cmp_cnt++;
         if (obs !== exp_v) begin mis_cnt++; $display("FAIL stall_frozen%0d: got %h expected %h", k, obs, exp_v); end
      end
      tick(1'b0, 1'b1, 1'b0, 32'h0, DH);
      exp_v = {1'b0, 32'd1, DH, DG};
      cmp_cnt++;
      if (obs !== exp_v) begin mis_cnt++; $display("FAIL stall_s2: got %h expected %h", obs, exp_v); end
      tick(1'b0, 1'b1, 1'b0, 32'h1, DI);
      exp_v = {1'b1, 32'd2, DH, DI};
      cmp_cnt++;
      if (obs !== exp_v) begin mis_cnt++; $display("FAIL stall_s3_done: got %h expected %h", obs, exp_v); end
   endtask

   task automatic test_restart;
      logic [96:0] exp_v;
      delay0 = 32'd0; amount = 32'd4;
      tick(1'b0, 1'b1, 1'b1, 32'h0, JUNK);
      tick(1'b0, 1'b1, 1'b0, 32'h1, DJ);
      tick(1'b0, 1'b1, 1'b0, 32'h1, DK);
      exp_v = {1'b0, 32'd2, DH, DK};
      cmp_cnt++;
      if (obs !== exp_v) begin mis_cnt++; $display("FAIL restart_partial: got %h expected %h", obs, exp_v); end
      // Run collides with a live sample: the sample must be discarded.
      tick(1'b0, 1'b1, 1'b1, 32'h1, JUNK);
      exp_v = {1'b0, 32'd0, DH, DK};
      cmp_cnt++;
      if (obs !== exp_v) begin mis_cnt++; $display("FAIL restart_run: got %h expected %h", obs, exp_v); end
      tick(1'b0, 1'b1, 1'b0, 32'h1, DL);
      tick(1'b0, 1'b1, 1'b0, 32'h0, DM);
      tick(1'b0, 1'b1, 1'b0, 32'h0, DN);
      exp_v = {1'b0, 32'd1, DN, DL};
      cmp_cnt++;
      if (obs !== exp_v) begin mis_cnt++; $display("FAIL restart_s3: got %h expected %h", obs, exp_v); end
      tick(1'b0, 1'b1, 1'b0, 32'h1, DP);
      exp_v = {1'b1, 32'd2, DN, DP};
      cmp_cnt++;
      if (obs !== exp_v) begin mis_cnt++; $display("FAIL restart_s4_done: got %h expected %h", obs, exp_v); end
      amount = 32'd0;
      tick(1'b0, 1'b0, 1'b1, 32'h1, JUNK);
      exp_v = {1'b1, 32'd0, DN, DP};
      cmp_cnt++;
      if (obs !== exp_v) begin mis_cnt++; $display("FAIL zero_amount_run: got %h expected %h", obs, exp_v); end
      tick(1'b0, 1'b1, 1'b0, 32'h1, JUNK);
      cmp_cnt++;
      if (obs !== exp_v) begin mis_cnt++; $display("FAIL zero_amount_idle: got %h expected %h", obs, exp_v); end
   endtask

   task automatic test_reset_mid_run;
      logic [96:0] exp_v;
      delay0 = 32'd0; amount = 32'd3;
      tick(1'b0, 1'b1, 1'b1, 32'h0, JUNK);
      tick(1'b0, 1'b1, 1'b0, 32'h1, DA);
      exp_v = {1'b0, 32'd1, DN, DA};
      cmp_cnt++;
      if (obs !== exp_v) begin mis_cnt++; $display("FAIL midrst_s1: got %h expected %h", obs, exp_v); end
      tick(1'b1, 1'b1, 1'b0, 32'h1, DB);
      exp_v = {1'b1, 32'd0, 32'd0, 32'd0};
      cmp_cnt++;
      if (obs !== exp_v) begin mis_cnt++; $display("FAIL midrst_reset: got %h expected %h", obs, exp_v); end
      tick(1'b0, 1'b1, 1'b0, 32'h1, DC);
      tick(1'b0, 1'b1, 1'b0, 32'h0, DD);
      cmp_cnt++;
      if (obs !== exp_v) begin mis_cnt++; $display("FAIL midrst_no_steer: got %h expected %h", obs, exp_v); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_delay();
      test_stall();
      test_restart();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
      $finish;
   end

endmodule

`default_nettype wire
